routing_lut_prog: RTL and testbench

- Runtime-programmable, pipelined address-to-route decoder for NI initiators; replaces fixed per-topology routing tables.
- Holds N_REGIONS address windows. Each window has a source route (first hop in LSBs, last hop in MSBs) and a target ID.
- Sits between the NI request front-end and the header packetiser.
- Supports table programming while traffic is flowing, and keeps a count of decode failures.

---
 rtl/routing_lut_prog_pkg.sv | 21 ++
 rtl/routing_lut_prog_region_match.sv | 17 +
 rtl/routing_lut_prog.sv | 135 +++++++++++++
 tb/tb_routing_lut_prog.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/routing_lut_prog_pkg.sv
// Shared routing definitions for the NI address decoder.
// Widths, route bit order and the miss encoding live here.
package routing_lut_prog_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int PATH_W_DEF = 7;
   localparam int TGT_W_DEF  = 4;

   // Hop 0 sits at bit 0 of the source route.
   localparam int ROUTE_FIRST_HOP_LSB = 0;

   localparam int FAIL_PATH   = 0;
   localparam int FAIL_TARGET = 0;
   localparam int FAIL_IDX    = 0;

   typedef struct packed {
      logic hit;
      logic fail;
   } lookup_flags_t;

endpackage

// File: rtl/routing_lut_prog_region_match.sv
// Single address-window comparator.
// Unsigned inclusive bounds; base > limit can never hit.
module routing_region_match
   import routing_lut_prog_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              en,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] limit,
   input  logic [ADDR_W-1:0] addr,
   output logic              hit
);

   assign hit = en && (addr >= base) && (addr <= limit);

endmodule

// File: rtl/routing_lut_prog.sv
// Programmable address-to-route decoder with a single registered
// response stage, lowest-index priority and a saturating miss counter.
module routing_lut_prog
   import routing_lut_prog_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int PATH_W    = PATH_W_DEF,
   parameter int TGT_W     = TGT_W_DEF,
   parameter int N_REGIONS = 8,
   parameter int IDX_W     = $clog2(N_REGIONS),
   parameter int CNT_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_en,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_limit,
   input  logic [PATH_W-1:0] cfg_path,
   input  logic [TGT_W-1:0]  cfg_target,
   input  logic              cnt_clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [PATH_W-1:0] resp_path,
   output logic [TGT_W-1:0]  resp_target,
   output logic              resp_fail,
   output logic [IDX_W-1:0]  resp_idx,
   output logic [CNT_W-1:0]  fail_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N_REGIONS-1:0] en_q;
   logic [ADDR_W-1:0]    base_q   [N_REGIONS];
   logic [ADDR_W-1:0]    limit_q  [N_REGIONS];
   logic [PATH_W-1:0]    path_q   [N_REGIONS];
   logic [TGT_W-1:0]     target_q [N_REGIONS];

   logic [N_REGIONS-1:0] hit;
   logic                 idx_ok;
   logic                 accept;
   lookup_flags_t        flags;
   logic [IDX_W-1:0]     sel_idx;
   logic [PATH_W-1:0]    lk_path;
   logic [TGT_W-1:0]     lk_target;
   logic [IDX_W-1:0]     lk_idx;

   assign idx_ok    = (32'(cfg_idx) < 32'(N_REGIONS));
   assign req_ready = !resp_valid || resp_ready;
   assign accept    = req_valid && req_ready;

   // Table writes land at the edge; a same-edge lookup sees old contents.
   always_ff @(posedge clock) begin
      if (reset) begin
         en_q <= '0;
         for (int i = 0; i < N_REGIONS; i++) begin
            base_q[i]   <= '0;
            limit_q[i]  <= '0;
            path_q[i]   <= '0;
            target_q[i] <= '0;
         end
      end else if (cfg_we && idx_ok) begin
         en_q[cfg_idx]     <= cfg_en;
         base_q[cfg_idx]   <= cfg_base;
         limit_q[cfg_idx]  <= cfg_limit;
         path_q[cfg_idx]   <= cfg_path;
         target_q[cfg_idx] <= cfg_target;
      end
   end

   for (genvar g = 0; g < N_REGIONS; g++) begin : g_match
      routing_region_match #(.ADDR_W(ADDR_W)) u_match (
         .en    (en_q[g]),
         .base  (base_q[g]),
         .limit (limit_q[g]),
         .addr  (req_addr),
         .hit   (hit[g])
      );
   end

   // Descending scan so the lowest hitting index is the last one kept.
   always_comb begin
      flags   = '0;
      sel_idx = '0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            flags.hit = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
      flags.fail = !flags.hit;
   end

   always_comb begin
      lk_path   = PATH_W'(FAIL_PATH);
      lk_target = TGT_W'(FAIL_TARGET);
      lk_idx    = IDX_W'(FAIL_IDX);
      if (flags.hit) begin
         lk_path   = path_q[sel_idx];
         lk_target = target_q[sel_idx];
         lk_idx    = sel_idx;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         resp_valid  <= 1'b0;
         resp_path   <= '0;
         resp_target <= '0;
         resp_fail   <= 1'b0;
         resp_idx    <= '0;
      end else if (accept) begin
         resp_valid  <= 1'b1;
         resp_path   <= lk_path;
         resp_target <= lk_target;
         resp_fail   <= flags.fail;
         resp_idx    <= lk_idx;
      end else if (resp_ready) begin
         resp_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || cnt_clr) begin
         fail_count <= '0;
      end else if (accept && flags.fail && fail_count != CNT_MAX) begin
         fail_count <= fail_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_routing_lut_prog.sv
// Directed bench for routing_lut_prog: 6 regions, 2-bit counter
// so saturation and the ignored out-of-range index are reachable.
module tb_routing_lut_prog;

   localparam int ADDR_W = 32;
   localparam int PATH_W = 7;
   localparam int TGT_W  = 4;
   localparam int NREG   = 6;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic              cfg_en;
   logic [ADDR_W-1:0] cfg_base;
   logic [ADDR_W-1:0] cfg_limit;
   logic [PATH_W-1:0] cfg_path;
   logic [TGT_W-1:0]  cfg_target;
   logic              cnt_clr;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_ready;
   logic [PATH_W-1:0] resp_path;
   logic [TGT_W-1:0]  resp_target;
   logic              resp_fail;
   logic [IDX_W-1:0]  resp_idx;
   logic [CNT_W-1:0]  fail_count;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   routing_lut_prog #(
      .ADDR_W(ADDR_W), .PATH_W(PATH_W), .TGT_W(TGT_W),
      .N_REGIONS(NREG), .IDX_W(IDX_W), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .reset(reset),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_base(cfg_base), .cfg_limit(cfg_limit),
      .cfg_path(cfg_path), .cfg_target(cfg_target),
      .cnt_clr(cnt_clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_path(resp_path), .resp_target(resp_target),
      .resp_fail(resp_fail), .resp_idx(resp_idx),
      .fail_count(fail_count)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic en,
                            input logic [31:0] b, input logic [31:0] l,
                            input logic [6:0] p, input logic [3:0] t);
      cfg_we = 1'b1; cfg_idx = idx; cfg_en = en;
      cfg_base = b; cfg_limit = l; cfg_path = p; cfg_target = t;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] a);
      req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic expect_resp(input string tag, input logic fl,
                              input logic [6:0] p, input logic [3:0] t,
                              input logic [2:0] i);
      check({tag, "_valid"}, 64'(resp_valid), 64'(1));
      check({tag, "_fail"}, 64'(resp_fail), 64'(fl));
      check({tag, "_path"}, 64'(resp_path), 64'(p));
      check({tag, "_tgt"}, 64'(resp_target), 64'(t));
      check({tag, "_idx"}, 64'(resp_idx), 64'(i));
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
      cfg_base = '0; cfg_limit = '0; cfg_path = '0; cfg_target = '0;
      cnt_clr = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
      step(); step();
      reset = 1'b0;
      check("rst_valid", 64'(resp_valid), 0);
      check("rst_ready", 64'(req_ready), 1);
      check("rst_cnt", 64'(fail_count), 0);
      check("rst_fail", 64'(resp_fail), 0);

      lookup(32'h0000_0000);
      expect_resp("empty", 1'b1, 7'h0, 4'h0, 3'd0);
      check("empty_cnt", 64'(fail_count), 1);

      cfg_write(3'd0, 1'b1, 32'h1000_0000, 32'h103F_FFFF, 7'h00, 4'h1);
      cfg_write(3'd1, 1'b1, 32'h1040_0000, 32'h107F_FFFF, 7'h01, 4'h5);
      lookup(32'h103F_FFFF);
      expect_resp("e0_top", 1'b0, 7'h00, 4'h1, 3'd0);
      lookup(32'h1040_0000);
      expect_resp("e1_bot", 1'b0, 7'h01, 4'h5, 3'd1);

      cfg_write(3'd2, 1'b1, 32'h1A00_0000, 32'h1FFF_FFFF, 7'h12, 4'hC);
      cfg_write(3'd3, 1'b1, 32'h1000_0000, 32'h1FFF_FFFF, 7'h23, 4'hB);
      lookup(32'h1B00_0000);
      expect_resp("ovl_2", 1'b0, 7'h12, 4'hC, 3'd2);
      lookup(32'h1200_0000);
      expect_resp("ovl_3", 1'b0, 7'h23, 4'hB, 3'd3);

      cfg_write(3'd4, 1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 7'h55, 4'h7);
      lookup(32'hFFFF_FFFF);
      expect_resp("top_win", 1'b0, 7'h55, 4'h7, 3'd4);

      cfg_write(3'd5, 1'b1, 32'h3000_0000, 32'h2FFF_FFFF, 7'h66, 4'h6);
      lookup(32'h3000_0000);
      expect_resp("inverted", 1'b1, 7'h0, 4'h0, 3'd0);
      check("cnt_2", 64'(fail_count), 2);

      cfg_write(3'd6, 1'b1, 32'h4000_0000, 32'h4FFF_FFFF, 7'h77, 4'h9);
      lookup(32'h4000_0000);
      expect_resp("bad_idx", 1'b1, 7'h0, 4'h0, 3'd0);
      check("cnt_3", 64'(fail_count), 3);
      lookup(32'h0800_0000);
      lookup(32'h0900_0000);
      check("cnt_sat", 64'(fail_count), 3);

      cnt_clr = 1'b1;
      lookup(32'h0A00_0000);
      cnt_clr = 1'b0;
      check("clr_wins", 64'(fail_count), 0);
      lookup(32'h0B00_0000);
      check("cnt_after_clr", 64'(fail_count), 1);

      step();
      check("idle_valid", 64'(resp_valid), 0);
      req_valid = 1'b1; req_addr = 32'h1000_0000; resp_ready = 1'b0;
      check("bp_ready0", 64'(req_ready), 1);
      step();
      req_addr = 32'h1040_0000;
      for (int k = 0; k < 3; k++) begin
         check("bp_ready", 64'(req_ready), 0);
         expect_resp("bp_hold", 1'b0, 7'h00, 4'h1, 3'd0);
         step();
      end
      resp_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(req_ready), 1);
      step();
      expect_resp("bp_b", 1'b0, 7'h01, 4'h5, 3'd1);
      req_addr = 32'h1B00_0000;
      step();
      expect_resp("bp_c", 1'b0, 7'h12, 4'hC, 3'd2);
      req_valid = 1'b0;
      step();
      check("bp_drain", 64'(resp_valid), 0);

      cfg_write(3'd3, 1'b0, 32'h1000_0000, 32'h1FFF_FFFF, 7'h23, 4'hB);
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b0;
      cfg_base = 32'h1000_0000; cfg_limit = 32'h103F_FFFF;
      cfg_path = 7'h00; cfg_target = 4'h1;
      lookup(32'h1000_0000);
      cfg_we = 1'b0;
      expect_resp("wr_same", 1'b0, 7'h00, 4'h1, 3'd0);
      lookup(32'h1000_0000);
      expect_resp("wr_next", 1'b1, 7'h0, 4'h0, 3'd0);

      req_valid = 1'b1; req_addr = 32'h1040_0000; resp_ready = 1'b0;
      step();
      req_valid = 1'b0;
      check("pre_rst_valid", 64'(resp_valid), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_rst_valid", 64'(resp_valid), 0);
      check("mid_rst_cnt", 64'(fail_count), 0);
      check("mid_rst_tgt", 64'(resp_target), 0);
      lookup(32'h1040_0000);
      expect_resp("post_rst_e1", 1'b1, 7'h0, 4'h0, 3'd0);
      lookup(32'h1000_0000);
      expect_resp("post_rst_e0", 1'b1, 7'h0, 4'h0, 3'd0);
      check("post_rst_cnt", 64'(fail_count), 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
